alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Operation sequencer that wraps the combinational ALU on both sides.
- Accepts operation requests over a valid/ready handshake.
- Registers the operands and select and drives them to the ALU's A, B and ALU_Sel inputs.
- Holds them stable for an op-dependent number of cycles, so multiply and divide are multicycle paths.
- Captures ZHigh/ZLow into result registers and presents them downstream over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/result half width
SEL_WIDTH, 16, ALU select width
MUL_CYCLES, 4, EXEC cycles for op 14 (multiply); legal range 1..255
DIV_CYCLES, 8, EXEC cycles for op 15 (divide); legal range 1..255

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request
req_op  in  SEL_WIDTH  ALU select code (1..15 legal)
req_a  in  DATA_WIDTH  operand A
req_b  in  DATA_WIDTH  operand B
alu_a  out  DATA_WIDTH  to ALU A
alu_b  out  DATA_WIDTH  to ALU B
alu_sel  out  SEL_WIDTH  to ALU_Sel
alu_zhigh  in  DATA_WIDTH  from ALU ZHigh
alu_zlow  in  DATA_WIDTH  from ALU ZLow
rsp_valid  out  1  result present
rsp_ready  in  1  downstream accepts result
rsp_zhigh  out  DATA_WIDTH  captured ZHigh
rsp_zlow  out  DATA_WIDTH  captured ZLow
rsp_op  out  SEL_WIDTH  op code of this result
rsp_wide  out  1  result is 64-bit (op 14 or 15)
rsp_err  out  1  illegal op, or divide with B==0

Behaviour:
- Clock and reset: single clock clk. clr is asynchronous and active-high.
- On clr, all of the following go to zero: every register, alu_a, alu_b, alu_sel, rsp_*; state = IDLE.
- On clr, any in-flight operation is discarded with no response.
- States: IDLE, EXEC, HOLD.
- req_ready = (state==IDLE) || (state==HOLD && rsp_ready). The handshake fires when req_valid && req_ready.
- Accept: latch req_a, req_b, req_op into op registers and go to EXEC. Load cnt:
  - MUL_CYCLES for op 14;
  - DIV_CYCLES for op 15;
  - 1 for all other ops.
- cnt is 8 bits.
- Error flag latched at accept: err = (op==0 || op>15) || (op==15 && req_b==0).
- Illegal ops still run 1 EXEC cycle; the ALU returns zero for them.
- alu_a/alu_b/alu_sel are driven from the op registers in EXEC and HOLD. They are held constant for the full EXEC duration.
- In IDLE, alu_sel = 0 (ALU output forced to zero); alu_a/alu_b keep their last values.
- EXEC: cnt decrements each cycle. On the edge where cnt==1:
  - capture alu_zhigh/alu_zlow into rsp_zhigh/rsp_zlow;
  - set rsp_op, rsp_wide=(op 14 or 15), rsp_err;
  - go to HOLD.
- Latency: request accepted at edge N → rsp_valid high after edge N+L, where L = cnt load value.
- HOLD: rsp_valid=1, and all rsp_* stay stable while rsp_ready=0 (backpressure of any length).
- In HOLD, when rsp_ready=1:
  - with req_valid=1: accept the new request on the same edge and go to EXEC; rsp_valid drops.
  - with req_valid=0: go to IDLE; rsp_valid drops; rsp_* data retains its value.
- req_valid is ignored in EXEC (req_ready=0). The requester must hold req_* stable until accepted.
- rsp_valid is never asserted in IDLE or EXEC.
- Throughput: for 1-cycle ops with rsp_ready tied high, one result every 2 cycles maximum.

Test Plan:
- Add: op=12, A=7, B=5, rsp_ready=1 → rsp_valid exactly 1 cycle after accept; rsp_zlow=12, rsp_zhigh=0, rsp_wide=0, rsp_err=0.
- Multiply: op=14, A=0x00010000, B=0x00010000 → rsp_valid 4 cycles after accept; zhigh=0x00000001, zlow=0x00000000, rsp_wide=1. alu_a/alu_b/alu_sel are constant over all 4 EXEC cycles.
- Divide by zero and illegal op:
  - op=15, A=17, B=0 → response after 8 cycles with rsp_err=1;
  - op=0, A=3, B=4 → after 1 cycle, zhigh=zlow=0, rsp_err=1.
- Backpressure/back-to-back: op=1, A=0xF0F0F0F0, B=0xFF00FF00, rsp_ready=0 for 3 cycles → rsp_valid and rsp_zlow=0xF000F000 stable, req_ready=0. Then raise rsp_ready with a queued op=13, A=10, B=3 → accepted on the same edge; next response zlow=7.
- Reset mid-op: op=15, A=100, B=7; assert clr asynchronously (between clock edges) in the 3rd EXEC cycle → all outputs zero immediately, state IDLE, req_ready=1 after clr drops, no stale response ever appears.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: brackets the combinational ALU with a request handshake on
// its input side and a response handshake on its output side. Operands and
// select are registered and held steady for an op-dependent number of cycles,
// which makes multiply and divide multicycle paths through the ALU.
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 16,
  parameter int MUL_CYCLES = 4,   // 1..255
  parameter int DIV_CYCLES = 8    // 1..255
) (
  input  logic                  clk,
  input  logic                  clr,
  // request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_WIDTH-1:0]  req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  // ALU side
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [SEL_WIDTH-1:0]  alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_zhigh,
  input  logic [DATA_WIDTH-1:0] alu_zlow,
  // response side
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_zhigh,
  output logic [DATA_WIDTH-1:0] rsp_zlow,
  output logic [SEL_WIDTH-1:0]  rsp_op,
  output logic                  rsp_wide,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  localparam logic [SEL_WIDTH-1:0] OP_MUL  = SEL_WIDTH'(14);
  localparam logic [SEL_WIDTH-1:0] OP_DIV  = SEL_WIDTH'(15);
  localparam logic [SEL_WIDTH-1:0] OP_MAX  = SEL_WIDTH'(15);
  localparam logic [7:0]           MUL_CNT = 8'(MUL_CYCLES);
  localparam logic [7:0]           DIV_CNT = 8'(DIV_CYCLES);

  state_t     state;
  logic [7:0] cnt;
  logic       err_q;

  logic       accept;
  logic [7:0] ld_cnt;
  logic       ld_err;
  logic       op_wide;

  // A waiting result frees the sequencer on the same edge it is consumed.
  assign req_ready = (state == IDLE) || (state == HOLD && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign op_wide   = (alu_sel == OP_MUL) || (alu_sel == OP_DIV);

  // Decode the incoming request: EXEC length and error flag.
  always_comb begin
    ld_cnt = 8'd1;
    if (req_op == OP_MUL)      ld_cnt = MUL_CNT;
    else if (req_op == OP_DIV) ld_cnt = DIV_CNT;
    ld_err = (req_op == '0) || (req_op > OP_MAX) ||
             ((req_op == OP_DIV) && (req_b == '0));
  end

  // Sequencer FSM; ALU drive and response fields are all registered here.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_zhigh <= '0;
      rsp_zlow  <= '0;
      rsp_op    <= '0;
      rsp_wide  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_sel <= req_op;
            cnt     <= ld_cnt;
            err_q   <= ld_err;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs are untouched for the whole EXEC window.
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            rsp_zhigh <= alu_zhigh;
            rsp_zlow  <= alu_zlow;
            rsp_op    <= alu_sel;
            rsp_wide  <= op_wide;
            rsp_err   <= err_q;
            rsp_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (req_valid) begin
              alu_a   <= req_a;
              alu_b   <= req_b;
              alu_sel <= req_op;
              cnt     <= ld_cnt;
              err_q   <= ld_err;
              state   <= EXEC;
            end else begin
              // Park the ALU on a zero result; operands keep their values.
              alu_sel <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU sits on the ALU port, a driver
// issues directed and random requests and pushes expected responses into a
// queue, and a negedge monitor checks every cycle against the queue head.
module tb_alu_op_sequencer;

  localparam int DW = 32;
  localparam int SW = 16;
  localparam int MULC = 4;
  localparam int DIVC = 8;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [SW-1:0] req_op = '0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [DW-1:0] alu_a, alu_b;
  logic [SW-1:0] alu_sel;
  logic [DW-1:0] alu_zhigh, alu_zlow;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_zhigh, rsp_zlow;
  logic [SW-1:0] rsp_op;
  logic          rsp_wide, rsp_err;

  alu_op_sequencer #(.DATA_WIDTH(DW), .SEL_WIDTH(SW), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_zhigh(alu_zhigh), .alu_zlow(alu_zlow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_zhigh(rsp_zhigh), .rsp_zlow(rsp_zlow),
    .rsp_op(rsp_op), .rsp_wide(rsp_wide), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {ZHigh, ZLow}; illegal selects give zero.
  function automatic logic [63:0] alu_f(input logic [SW-1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [31:0] lo;
    lo = '0;
    case (s)
      16'd1:  lo = a & b;
      16'd2:  lo = a | b;
      16'd3:  lo = a ^ b;
      16'd4:  lo = ~a;
      16'd5:  lo = a << b[4:0];
      16'd6:  lo = a >> b[4:0];
      16'd7:  lo = a + 32'd1;
      16'd8:  lo = a - 32'd1;
      16'd9:  lo = ~(a & b);
      16'd10: lo = ~(a | b);
      16'd11: lo = ~(a ^ b);
      16'd12: lo = a + b;
      16'd13: lo = a - b;
      16'd14: return {32'd0, a} * {32'd0, b};
      16'd15: return (b == 0) ? 64'd0 : {a % b, a / b};
      default: lo = '0;
    endcase
    return {32'd0, lo};
  endfunction

  assign {alu_zhigh, alu_zlow} = alu_f(alu_sel, alu_a, alu_b);

  typedef struct {
    logic [SW-1:0] op;
    logic [DW-1:0] a, b, zh, zl;
    logic          wide, err;
    int            first;   // edge count after which rsp_valid must be high
  } exp_t;

  exp_t sb[$];
  int   nvec = 0, nerr = 0;
  int   cyc = 0;
  bit   started = 0, in_rst = 0, seen = 0, rr_rand = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Random downstream backpressure when enabled.
  always @(posedge clk) if (rr_rand) begin
    #1 rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, want);
    end
  endtask

  // Monitor: idle checks with nothing in flight, ALU hold checks during EXEC,
  // latency/field/stability checks while a response is presented.
  always @(negedge clk) if (started && !in_rst) begin
    if (sb.size() == 0) begin
      chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("idle_alu_sel", 64'(alu_sel), 64'd0);
    end else if (!rsp_valid) begin
      chk("exec_alu_a", 64'(alu_a), 64'(sb[0].a));
      chk("exec_alu_b", 64'(alu_b), 64'(sb[0].b));
      chk("exec_alu_sel", 64'(alu_sel), 64'(sb[0].op));
      chk("exec_req_ready", 64'(req_ready), 64'd0);
    end else begin
      if (!seen) begin
        chk("latency", 64'(cyc), 64'(sb[0].first));
        seen = 1;
      end
      chk("rsp_zhigh", 64'(rsp_zhigh), 64'(sb[0].zh));
      chk("rsp_zlow", 64'(rsp_zlow), 64'(sb[0].zl));
      chk("rsp_op", 64'(rsp_op), 64'(sb[0].op));
      chk("rsp_wide", 64'(rsp_wide), 64'(sb[0].wide));
      chk("rsp_err", 64'(rsp_err), 64'(sb[0].err));
      chk("hold_req_ready", 64'(req_ready), 64'(rsp_ready));
      if (rsp_ready) begin
        void'(sb.pop_front());
        seen = 0;
      end
    end
  end

  // Present one request until accepted, then queue its expected response.
  task automatic issue(input logic [SW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    logic [63:0] r;
    int t;
    bit go;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    t = 0; go = 0;
    while (!go && t < 200) begin
      @(negedge clk);
      go = req_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!go) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: req_ready never high for op %0d", op);
    end else begin
      r      = alu_f(op, a, b);
      e.op   = op; e.a = a; e.b = b;
      e.zh   = r[63:32]; e.zl = r[31:0];
      e.wide = (op == 14) || (op == 15);
      e.err  = (op == 0) || (op > 15) || (op == 15 && b == 0);
      e.first = cyc + ((op == 14) ? MULC : (op == 15) ? DIVC : 1);
      sb.push_back(e);
    end
    req_valid = 1'b0;
    req_op = SW'($urandom); req_a = $urandom; req_b = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
      sb.delete();
      seen = 0;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({tag, "_alu_sel"}, 64'(alu_sel), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_zhigh"}, 64'(rsp_zhigh), 64'd0);
    chk({tag, "_rsp_zlow"}, 64'(rsp_zlow), 64'd0);
    chk({tag, "_rsp_op"}, 64'(rsp_op), 64'd0);
    chk({tag, "_rsp_wide"}, 64'(rsp_wide), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
  endtask

  initial begin
    logic [SW-1:0] op;
    logic [DW-1:0] a, b;
    int r;

    // Reset state
    #2;
    chk_zero_outputs("reset");
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    started = 1;

    // Add, multiply, divide-by-zero, illegal op
    rsp_ready = 1'b1;
    issue(16'd12, 32'd7, 32'd5);           drain();
    issue(16'd14, 32'h00010000, 32'h00010000); drain();
    issue(16'd15, 32'd17, 32'd0);          drain();
    issue(16'd0, 32'd3, 32'd4);            drain();
    issue(16'd15, 32'd100, 32'd7);         drain();
    issue(16'd200, 32'd9, 32'd9);          drain();

    // Backpressure for 3 cycles, then back-to-back accept on release
    rsp_ready = 1'b0;
    issue(16'd1, 32'hF0F0F0F0, 32'hFF00FF00);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    issue(16'd13, 32'd10, 32'd3);
    drain();

    // Asynchronous reset in the 3rd EXEC cycle of a divide
    issue(16'd15, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #3;
    in_rst = 1;
    clr = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    sb.delete();
    seen = 0;
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    in_rst = 0;
    repeat (12) @(posedge clk);
    #1;

    // Random traffic with random backpressure and gaps
    rr_rand = 1;
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 19);
      op = (r < 16) ? SW'(r) : SW'($urandom_range(16, 65535));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = {27'd0, b[4:0]};
      issue(op, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    @(posedge clk);
    rr_rand = 0;
    #2;
    rsp_ready = 1'b1;
    drain();
    repeat (4) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    nerr++;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "timeout");
  end

endmodule
